// File: rtl/alu_issue_pkg.sv
// Shared RV32I decode constants and the ALU op encoding understood by the downstream ALU.
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9,
    ALU_EQ   = 5'd10
  } alu_op_e;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Issue-slot to ALU operand channel: valid/ready plus the decoded op and operands.
interface alu_issue_if #(parameter int unsigned XLEN = 32);
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_op;
  logic [XLEN-1:0] out_lhs;
  logic [XLEN-1:0] out_rhs;
  logic [4:0]      out_rd;
  logic            out_we;
  logic            out_illegal;

  modport master (
    output out_valid, out_op, out_lhs, out_rhs, out_rd, out_we, out_illegal,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_op, out_lhs, out_rhs, out_rd, out_we, out_illegal,
    output out_ready
  );
endinterface

// File: rtl/alu_issue_imm.sv
// Combinational I-type (sign-extended) and U-type immediate generator.
module alu_issue_imm (
  input  logic [31:12] inst,
  output logic [31:0]  imm_i,
  output logic [31:0]  imm_u
);
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_u = {inst[31:12], 12'b0};
endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage ahead of the ALU: decodes OP/OP-IMM/LUI/AUIPC, blocks RAW hazards
// through a pending-write scoreboard and holds the result in a registered output slot.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            CLK,
  input  logic            RST_X,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  alu_issue_if.master     out
);

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_u, rs1_val, rs2_val;
  logic [XLEN-1:0] lhs, rhs;
  alu_op_e         op;
  logic            illegal, we, uses_rs1, uses_rs2, hazard, accept;
  logic [NREG-1:0] pend_q, pend_d;
  state_e          state_q, state_d;

  logic            slot_valid, slot_we, slot_illegal;
  logic [4:0]      slot_op, slot_rd;
  logic [XLEN-1:0] slot_lhs, slot_rhs;

  assign opcode   = in_inst[6:0];
  assign rd       = in_inst[11:7];
  assign funct3   = in_inst[14:12];
  assign funct7   = in_inst[31:25];
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];
  assign rs1_val  = (rs1_addr == '0) ? '0 : rs1_data;
  assign rs2_val  = (rs2_addr == '0) ? '0 : rs2_data;

  alu_issue_imm u_imm (
    .inst  (in_inst[31:12]),
    .imm_i (imm_i),
    .imm_u (imm_u)
  );

  always_comb begin
    op       = ALU_ADD;
    lhs      = '0;
    rhs      = '0;
    illegal  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        lhs      = rs1_val;
        rhs      = rs2_val;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          op = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        uses_rs1 = 1'b1;
        lhs      = rs1_val;
        rhs      = imm_i;
        case (funct3)
          F3_ADD:  op = ALU_ADD;
          F3_SLT:  op = ALU_SLT;
          F3_SLTU: op = ALU_SLTU;
          F3_XOR:  op = ALU_XOR;
          F3_OR:   op = ALU_OR;
          F3_AND:  op = ALU_AND;
          F3_SLL: begin
            op      = ALU_SLL;
            illegal = (funct7 != F7_BASE);
          end
          default: begin
            op      = in_inst[30] ? ALU_SRA : ALU_SRL;
            illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
        endcase
      end
      OPC_LUI: rhs = imm_u;
      OPC_AUIPC: begin
        lhs = in_pc;
        rhs = imm_u;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      op  = ALU_ADD;
      lhs = '0;
      rhs = '0;
    end
    // The ALU shifts by the full rhs, so the amount is trimmed here.
    if (is_shift(op))
      rhs = {{(XLEN-5){1'b0}}, rhs[4:0]};
  end

  assign we       = !illegal && (rd != '0);
  assign hazard   = in_valid && ((uses_rs1 && pend_q[rs1_addr]) || (uses_rs2 && pend_q[rs2_addr]));
  assign in_ready = (!slot_valid || out.out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Clear before set so a same-cycle retire of an older write cannot erase the new pending one.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (wb_valid) pend_d[wb_rd] = 1'b0;
      if (accept && we) pend_d[rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (hazard) state_d = ST_STALL;
        ST_STALL: if (!hazard) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q      <= ST_RUN;
      pend_q       <= '0;
      slot_valid   <= 1'b0;
      slot_op      <= '0;
      slot_lhs     <= '0;
      slot_rhs     <= '0;
      slot_rd      <= '0;
      slot_we      <= 1'b0;
      slot_illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (flush) begin
        slot_valid <= 1'b0;
      end else if (accept) begin
        slot_valid   <= 1'b1;
        slot_op      <= op;
        slot_lhs     <= lhs;
        slot_rhs     <= rhs;
        slot_rd      <= rd;
        slot_we      <= we;
        slot_illegal <= illegal;
      end else if (out.out_ready) begin
        slot_valid <= 1'b0;
      end
    end
  end

  assign out.out_valid   = slot_valid;
  assign out.out_op      = slot_op;
  assign out.out_lhs     = slot_lhs;
  assign out.out_rhs     = slot_rhs;
  assign out.out_rd      = slot_rd;
  assign out.out_we      = slot_we;
  assign out.out_illegal = slot_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Randomised and directed bench for alu_issue against a cycle-level behavioural model.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic        in_valid, in_ready, wb_valid, flush;
  logic [31:0] in_inst, in_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, wb_rd;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_issue_if #(.XLEN(32)) aif ();

  alu_issue #(.XLEN(32), .NREG(32)) dut (
    .CLK      (CLK),
    .RST_X    (RST_X),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inst  (in_inst),
    .in_pc    (in_pc),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .flush    (flush),
    .out      (aif)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  rd;
    bit          we;
    bit          ill;
    bit          u1;
    bit          u2;
  } exp_t;

  bit   m_pend [32];
  bit   m_valid;
  exp_t m_out;
  bit   last_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] d1, input logic [31:0] d2);
    exp_t        e;
    logic [4:0]  rr_ops [8];
    logic [31:0] a, b, immi, immu;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    bit          ok;
    rr_ops = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    opc  = inst[6:0];
    f3   = inst[14:12];
    f7   = inst[31:25];
    a    = (inst[19:15] == 5'd0) ? 32'd0 : d1;
    b    = (inst[24:20] == 5'd0) ? 32'd0 : d2;
    immi = 32'($signed(inst[31:20]));
    immu = inst & 32'hFFFF_F000;
    e    = '{op: ALU_ADD, lhs: 0, rhs: 0, rd: inst[11:7], we: 0, ill: 0, u1: 0, u2: 0};
    ok   = 0;
    if (opc == 7'h33) begin
      e.u1 = 1; e.u2 = 1; e.lhs = a; e.rhs = b;
      if (f7 == 7'h00) begin ok = 1; e.op = rr_ops[f3]; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; e.op = ALU_SUB; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; e.op = ALU_SRA; end
    end else if (opc == 7'h13) begin
      e.u1 = 1; e.lhs = a; e.rhs = immi;
      if (f3 == 3'd1) begin ok = (f7 == 7'h00); e.op = ALU_SLL; end
      else if (f3 == 3'd5) begin ok = (f7 == 7'h00 || f7 == 7'h20); e.op = inst[30] ? ALU_SRA : ALU_SRL; end
      else begin ok = 1; e.op = rr_ops[f3]; end
    end else if (opc == 7'h37) begin
      ok = 1; e.lhs = 0; e.rhs = immu;
    end else if (opc == 7'h17) begin
      ok = 1; e.lhs = pc; e.rhs = immu;
    end
    if (!ok) begin e.op = ALU_ADD; e.lhs = 0; e.rhs = 0; end
    if (e.op == ALU_SLL || e.op == ALU_SRL || e.op == ALU_SRA) e.rhs = e.rhs % 32;
    e.ill = !ok;
    e.we  = ok && (e.rd != 0);
    return e;
  endfunction

  // One clock: check combinational outputs before the edge, advance model, check slot after.
  task automatic step();
    exp_t d;
    bit   hz, er;
    #1;
    d  = ref_decode(in_inst, in_pc, rs1_data, rs2_data);
    hz = in_valid && ((d.u1 && m_pend[in_inst[19:15]]) || (d.u2 && m_pend[in_inst[24:20]]));
    er = (!m_valid || aif.out_ready) && !hz && !flush;
    check("in_ready", {31'd0, in_ready}, {31'd0, er});
    check("rs1_addr", {27'd0, rs1_addr}, {27'd0, in_inst[19:15]});
    check("rs2_addr", {27'd0, rs2_addr}, {27'd0, in_inst[24:20]});
    last_ready = in_ready;
    @(posedge CLK);
    if (!RST_X) begin
      m_valid = 0;
      m_out   = '{op: 0, lhs: 0, rhs: 0, rd: 0, we: 0, ill: 0, u1: 0, u2: 0};
      foreach (m_pend[i]) m_pend[i] = 0;
    end else if (flush) begin
      m_valid = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      if (wb_valid) m_pend[wb_rd] = 0;
      if (in_valid && er) begin
        m_out   = d;
        m_valid = 1;
        if (d.we) m_pend[d.rd] = 1;
      end else if (aif.out_ready) begin
        m_valid = 0;
      end
      m_pend[0] = 0;
    end
    #1;
    check("out_valid",   {31'd0, aif.out_valid},   {31'd0, m_valid});
    check("out_op",      {27'd0, aif.out_op},      {27'd0, m_out.op});
    check("out_lhs",     aif.out_lhs,              m_out.lhs);
    check("out_rhs",     aif.out_rhs,              m_out.rhs);
    check("out_rd",      {27'd0, aif.out_rd},      {27'd0, m_out.rd});
    check("out_we",      {31'd0, aif.out_we},      {31'd0, m_out.we});
    check("out_illegal", {31'd0, aif.out_illegal}, {31'd0, m_out.ill});
    @(negedge CLK);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] r1, r2, rdx;
    r1  = 5'($urandom % 8);
    r2  = 5'($urandom % 8);
    rdx = 5'($urandom % 8);
    f3  = 3'($urandom);
    case ($urandom % 8)
      0, 1: begin
        f7 = ($urandom % 2 == 0) ? 7'h00 : 7'h20;
        return {f7, r2, r1, f3, rdx, 7'h33};
      end
      2: return {7'($urandom), r2, r1, f3, rdx, 7'h33};
      3, 4: begin
        case ($urandom % 4)
          0: f7 = 7'h00;
          1: f7 = 7'h20;
          default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom), r1, f3, rdx, 7'h13};
      end
      5: return {20'($urandom), rdx, 7'h37};
      6: return {20'($urandom), rdx, 7'h17};
      default: return $urandom;
    endcase
  endfunction

  logic [4:0]  held_op, held_rd;
  logic [31:0] held_lhs;

  initial begin
    RST_X = 0; in_valid = 0; in_inst = 0; in_pc = 0; rs1_data = 0; rs2_data = 0;
    wb_valid = 0; wb_rd = 0; flush = 0; aif.out_ready = 1;
    m_valid = 0;
    m_out   = '{op: 0, lhs: 0, rhs: 0, rd: 0, we: 0, ill: 0, u1: 0, u2: 0};
    foreach (m_pend[i]) m_pend[i] = 0;
    @(negedge CLK);
    step(); step();
    check("rst_valid", {31'd0, aif.out_valid}, 32'd0);
    RST_X = 1;

    // ADDI x1,x0,5
    in_valid = 1; in_inst = 32'h0050_0093; rs1_data = 32'hDEAD_BEEF;
    step();
    check("addi_op",  {27'd0, aif.out_op}, {27'd0, ALU_ADD});
    check("addi_lhs", aif.out_lhs, 32'd0);
    check("addi_rhs", aif.out_rhs, 32'd5);
    check("addi_rd",  {27'd0, aif.out_rd}, 32'd1);
    check("addi_we",  {31'd0, aif.out_we}, 32'd1);

    // ADD x2,x1,x1 waits on x1 until the cycle after its writeback
    in_inst = 32'h0010_8133;
    step(); check("raw_stall", {31'd0, last_ready}, 32'd0);
    step();
    wb_valid = 1; wb_rd = 1;
    step(); check("wb_same_cycle", {31'd0, last_ready}, 32'd0);
    wb_valid = 0;
    step(); check("raw_release", {31'd0, last_ready}, 32'd1);
    check("add_rd", {27'd0, aif.out_rd}, 32'd2);

    // SRA x3,x4,x5 with an over-wide shift amount
    in_inst = 32'h4052_51B3; rs1_data = 32'h8000_0000; rs2_data = 32'h25;
    step();
    check("sra_op",  {27'd0, aif.out_op}, {27'd0, ALU_SRA});
    check("sra_rhs", aif.out_rhs, 32'd5);
    check("sra_lhs", aif.out_lhs, 32'h8000_0000);

    // Backpressure: slot holds and the offered ADDI x6 is taken only once ready returns
    held_op = aif.out_op; held_rd = aif.out_rd; held_lhs = aif.out_lhs;
    aif.out_ready = 0; in_inst = 32'h0070_0313;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_ready", {31'd0, last_ready}, 32'd0);
      check("bp_rd",    {27'd0, aif.out_rd}, {27'd0, held_rd});
      check("bp_op",    {27'd0, aif.out_op}, {27'd0, held_op});
      check("bp_lhs",   aif.out_lhs, held_lhs);
    end
    aif.out_ready = 1;
    step();
    check("bp_taken", {27'd0, aif.out_rd}, 32'd6);

    // Flush with x1 pending and the slot full
    in_inst = 32'h0050_0093;
    step();
    in_valid = 0; flush = 1;
    step();
    check("flush_valid", {31'd0, aif.out_valid}, 32'd0);
    flush = 0; in_valid = 1; in_inst = 32'h0010_8133;
    step();
    check("flush_pend", {31'd0, last_ready}, 32'd1);

    // Undecodable word
    in_inst = 32'hFFFF_FFFF;
    step();
    check("ill_flag", {31'd0, aif.out_illegal}, 32'd1);
    check("ill_we",   {31'd0, aif.out_we}, 32'd0);

    // Reset in the middle of a stall
    wb_valid = 1; wb_rd = 2;
    in_inst = 32'h0050_0093;
    step();
    wb_valid = 0; in_inst = 32'h0010_8133;
    step();
    RST_X = 0;
    step();
    check("rst_mid_valid", {31'd0, aif.out_valid}, 32'd0);
    check("rst_mid_rhs",   aif.out_rhs, 32'd0);
    check("rst_mid_rd",    {27'd0, aif.out_rd}, 32'd0);
    RST_X = 1;
    step();
    check("rst_mid_pend", {31'd0, last_ready}, 32'd1);

    for (int n = 0; n < 3000; n++) begin
      RST_X         = ($urandom % 200) != 0;
      in_valid      = ($urandom % 4) != 0;
      in_inst       = rand_inst();
      in_pc         = $urandom;
      rs1_data      = $urandom;
      rs2_data      = $urandom;
      wb_valid      = ($urandom % 3) == 0;
      wb_rd         = 5'($urandom % 8);
      flush         = ($urandom % 40) == 0;
      aif.out_ready = ($urandom % 4) != 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
